stack_resolver: RTL and testbench

- Downstream consumer of the row shifter: latches each stopped row, intersects it with the row below and writes the survivors into an 8-row stack.
- Drives the next row's starting block pattern and the shifter's start level.
- Declares game over or win.
- Sits between the shifter and the LED-matrix display driver.

---
 rtl/stack_resolver.sv | 101 ++++++++++
 tb/tb_stack_resolver.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/stack_resolver.sv
// Stack resolver: captures each stopped row from the shifter, intersects it with
// the row below, records survivors in the stack and sequences launch/win/over.
module stack_resolver #(
  parameter int         ROWS       = 8,
  parameter logic [7:0] INIT_BLOCK = 8'b00111000,
  localparam int        RW         = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int        SW         = $clog2(ROWS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              newGame,
  input  logic              rowDone,
  input  logic [7:0]        rowBlock,
  output logic              startRow,
  output logic [7:0]        nextBlock,
  output logic [RW-1:0]     rowIndex,
  output logic [8*ROWS-1:0] stackFlat,
  output logic [SW-1:0]     score,
  output logic              gameOver,
  output logic              gameWin
);

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, RESOLVE, OVER, WIN} stateT;

  stateT                 state, stateNext;
  logic [ROWS-1:0][7:0]  stack;
  logic [7:0]            captured;
  logic                  armed;
  logic [7:0]            below;
  logic [7:0]            landed;
  logic                  lastRow;

  // Row 0 lands on the floor, so it keeps everything it was stopped with.
  assign below   = (rowIndex == '0) ? 8'hFF : stack[rowIndex - 1'b1];
  assign landed  = captured & below;
  assign lastRow = rowIndex == RW'(ROWS - 1);

  assign stackFlat = stack;
  assign startRow  = (state == WAIT) || (state == RESOLVE);
  assign gameOver  = state == OVER;
  assign gameWin   = state == WIN;

  always_comb begin
    stateNext = state;
    case (state)
      IDLE, OVER, WIN: if (newGame) stateNext = LAUNCH;
      LAUNCH:          stateNext = WAIT;
      WAIT:            if (rowDone && armed) stateNext = RESOLVE;
      RESOLVE: begin
        if (landed == 8'h00) stateNext = OVER;
        else if (lastRow)    stateNext = WIN;
        else                 stateNext = LAUNCH;
      end
      default:         stateNext = IDLE;
    endcase
    // A restart request overrides whatever the current row was doing.
    if (newGame) stateNext = LAUNCH;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      stack     <= '0;
      rowIndex  <= '0;
      score     <= '0;
      nextBlock <= INIT_BLOCK;
      armed     <= 1'b0;
      captured  <= 8'h00;
    end else begin
      state <= stateNext;
      if (newGame) begin
        stack     <= '0;
        rowIndex  <= '0;
        score     <= '0;
        nextBlock <= INIT_BLOCK;
        armed     <= 1'b0;
      end else begin
        case (state)
          LAUNCH: armed <= 1'b0;
          // Only a stop flag seen after a low is fresh; a held-over high is stale.
          WAIT: begin
            if (!rowDone)   armed    <= 1'b1;
            else if (armed) captured <= rowBlock;
          end
          RESOLVE: begin
            stack[rowIndex] <= landed;
            if (landed != 8'h00) begin
              if (score < SW'(ROWS)) score <= score + 1'b1;
              if (!lastRow) begin
                rowIndex  <= rowIndex + 1'b1;
                nextBlock <= landed;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stack_resolver.sv
// Bench for stack_resolver: scripted vector table, hand-written corner sequences
// and randomized games checked against an array-based model of the game rules.
module tb_stack_resolver;

  logic        clk;
  logic        rst;
  logic        newGame;
  logic        rowDone;
  logic [7:0]  rowBlock;
  logic        startRow;
  logic [7:0]  nextBlock;
  logic [2:0]  rowIndex;
  logic [63:0] stackFlat;
  logic [3:0]  score;
  logic        gameOver;
  logic        gameWin;

  int nTotal = 0;
  int nPass  = 0;

  stack_resolver dut (
    .clk(clk), .rst(rst), .newGame(newGame), .rowDone(rowDone), .rowBlock(rowBlock),
    .startRow(startRow), .nextBlock(nextBlock), .rowIndex(rowIndex),
    .stackFlat(stackFlat), .score(score), .gameOver(gameOver), .gameWin(gameWin)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] blk;
    logic [7:0] expRow;
    logic [3:0] expScore;
    logic [2:0] expIndex;
    logic [7:0] expNext;
    logic       expOver;
  } vecT;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nTotal++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulseNewGame();
    newGame = 1'b1;
    step();
    newGame = 1'b0;
  endtask

  // Shifter-like handshake: wait for start high, drop the stop flag for a cycle,
  // then stop with blk and hold it until the resolver takes start away.
  task automatic playRow(input logic [7:0] blk);
    int n = 0;
    while (!startRow && n < 10) begin step(); n++; end
    if (!startRow) chk("waitStartHigh", {63'd0, startRow}, 64'd1);
    rowDone = 1'b0;
    step();
    rowBlock = blk;
    rowDone  = 1'b1;
    step();
    step();
    rowDone = 1'b0;
  endtask

  vecT vecs[3];
  logic [7:0]  m[8];
  logic [63:0] flat;
  logic [7:0]  mNext;
  logic [7:0]  blk, lnd;
  int          mScore, mIdx;
  logic        mOver, mWin;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{8'b00011100, 8'b00011100, 4'd1, 3'd1, 8'b00011100, 1'b0};
    vecs[1] = '{8'b00001110, 8'b00001100, 4'd2, 3'd2, 8'b00001100, 1'b0};
    vecs[2] = '{8'b11000000, 8'b00000000, 4'd2, 3'd2, 8'b00001100, 1'b1};

    rst = 1'b1; newGame = 1'b0; rowDone = 1'b0; rowBlock = 8'h00;
    step(); step();
    chk("rstStart",  {63'd0, startRow}, 64'd0);
    chk("rstNext",   {56'd0, nextBlock}, 64'h38);
    chk("rstIndex",  {61'd0, rowIndex}, 64'd0);
    chk("rstStack",  stackFlat, 64'd0);
    chk("rstScore",  {60'd0, score}, 64'd0);
    chk("rstFlags",  {62'd0, gameOver, gameWin}, 64'd0);
    rst = 1'b0;
    step();
    chk("idleStart", {63'd0, startRow}, 64'd0);

    // Launch: one cycle of start low, then high.
    pulseNewGame();
    chk("launchLow",  {63'd0, startRow}, 64'd0);
    chk("launchNext", {56'd0, nextBlock}, 64'h38);
    step();
    chk("launchHigh", {63'd0, startRow}, 64'd1);

    // Scripted game ending in a disjoint placement.
    for (int i = 0; i < 3; i++) begin
      playRow(vecs[i].blk);
      chk($sformatf("vecRow%0d", i),   {56'd0, stackFlat[8*i +: 8]}, {56'd0, vecs[i].expRow});
      chk($sformatf("vecScore%0d", i), {60'd0, score}, {60'd0, vecs[i].expScore});
      chk($sformatf("vecIdx%0d", i),   {61'd0, rowIndex}, {61'd0, vecs[i].expIndex});
      chk($sformatf("vecNext%0d", i),  {56'd0, nextBlock}, {56'd0, vecs[i].expNext});
      chk($sformatf("vecOver%0d", i),  {63'd0, gameOver}, {63'd0, vecs[i].expOver});
      chk($sformatf("vecStLow%0d", i), {63'd0, startRow}, 64'd0);
      step();
      chk($sformatf("vecStNext%0d", i), {63'd0, startRow}, vecs[i].expOver ? 64'd0 : 64'd1);
    end
    step(); step();
    chk("overHold",  {62'd0, gameOver, gameWin}, 64'd2);
    chk("overStack", stackFlat, 64'h0000_0000_000C_1C);
    pulseNewGame();
    chk("restartOver",  {63'd0, gameOver}, 64'd0);
    chk("restartStack", stackFlat, 64'd0);
    chk("restartScore", {60'd0, score}, 64'd0);

    // Perfect stack to a win.
    for (int r = 0; r < 8; r++) playRow(8'h38);
    chk("winFlag",  {62'd0, gameOver, gameWin}, 64'd1);
    chk("winScore", {60'd0, score}, 64'd8);
    chk("winIdx",   {61'd0, rowIndex}, 64'd7);
    chk("winStack", stackFlat, {8{8'h38}});
    chk("winStart", {63'd0, startRow}, 64'd0);
    step(); step();
    chk("winHold",  {62'd0, gameOver, gameWin}, 64'd1);

    // Stop flag held high across launch must not be captured.
    newGame = 1'b1; rowDone = 1'b1; rowBlock = 8'hFF;
    step();
    newGame = 1'b0;
    step(); step(); step();
    chk("staleStack", stackFlat, 64'd0);
    chk("staleWait",  {63'd0, startRow}, 64'd1);
    rowDone = 1'b0;
    step();
    rowBlock = 8'h18; rowDone = 1'b1;
    step();
    chk("latencyPre", stackFlat, 64'd0);
    step();
    chk("latencyRow", stackFlat, 64'h18);
    chk("latencySc",  {60'd0, score}, 64'd1);
    rowDone = 1'b0;
    step(); step();

    // newGame together with a stop in WAIT: restart, nothing written.
    step();
    rowBlock = 8'h10; rowDone = 1'b1; newGame = 1'b1;
    step();
    newGame = 1'b0; rowDone = 1'b0;
    chk("ngWaitStack", stackFlat, 64'd0);
    chk("ngWaitIdx",   {61'd0, rowIndex}, 64'd0);
    chk("ngWaitStart", {63'd0, startRow}, 64'd0);

    // newGame in RESOLVE beats the stack write.
    step(); step();
    rowBlock = 8'h3C; rowDone = 1'b1;
    step();
    newGame = 1'b1;
    step();
    newGame = 1'b0; rowDone = 1'b0;
    chk("ngResStack", stackFlat, 64'd0);
    chk("ngResScore", {60'd0, score}, 64'd0);

    // Asynchronous reset in the middle of WAIT.
    playRow(8'h38);
    step();
    #2 rst = 1'b1;
    #1;
    chk("asyncStack", stackFlat, 64'd0);
    chk("asyncScore", {60'd0, score}, 64'd0);
    chk("asyncStart", {63'd0, startRow}, 64'd0);
    chk("asyncIdx",   {61'd0, rowIndex}, 64'd0);
    step();
    rst = 1'b0;
    step();

    // Random games against the rule-level model.
    for (int g = 0; g < 25; g++) begin
      pulseNewGame();
      for (int r = 0; r < 8; r++) m[r] = 8'h00;
      mNext = 8'h38; mScore = 0; mIdx = 0; mOver = 1'b0; mWin = 1'b0;
      for (int r = 0; r < 8; r++) begin
        if (($urandom % 4) != 0) blk = mNext | 8'($urandom & $urandom);
        else                     blk = 8'($urandom);
        playRow(blk);
        lnd  = blk & ((r == 0) ? 8'hFF : m[r-1]);
        m[r] = lnd;
        if (lnd == 8'h00) mOver = 1'b1;
        else begin
          mScore++;
          if (r == 7) mWin = 1'b1;
          else begin mIdx = r + 1; mNext = lnd; end
        end
        for (int k = 0; k < 8; k++) flat[8*k +: 8] = m[k];
        chk($sformatf("rnd%0d.%0d stack", g, r), stackFlat, flat);
        chk($sformatf("rnd%0d.%0d score", g, r), {60'd0, score}, 64'(mScore));
        chk($sformatf("rnd%0d.%0d idx", g, r),   {61'd0, rowIndex}, 64'(mIdx));
        chk($sformatf("rnd%0d.%0d next", g, r),  {56'd0, nextBlock}, {56'd0, mNext});
        chk($sformatf("rnd%0d.%0d flags", g, r), {62'd0, gameOver, gameWin}, {62'd0, mOver, mWin});
        if (mOver || mWin) break;
      end
      step();
    end

    $display("%0d/%0d checks passed", nPass, nTotal);
    $finish;
  end

endmodule
